// File: rtl/iq_ram_rd_sched.sv
// Per-symbol IQ RAM read scheduler: reads one antenna bank at a time, paced by downstream
// readiness, and delay-matches the valid/bank/PRB tags to the RAM read latency.
module iq_ram_rd_sched #(
    parameter int ANT     = 8,
    parameter int NUM_PRB = 132,
    parameter int AW      = 8,
    parameter int RD_LAT  = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [1:0]        i_wr_done,
    input  logic              i_ds_ready,
    output logic [ANT-1:0]    o_ren,
    output logic [ANT*AW-1:0] o_raddr,
    output logic              o_rd_vld,
    output logic              o_rd_bank,
    output logic [AW-1:0]     o_rd_prb,
    output logic              o_sym_done,
    output logic              o_busy,
    output logic              o_ovf
);

    localparam int           HALF      = ANT / 2;
    localparam logic [1:0]   ST_IDLE   = 2'd0;
    localparam logic [1:0]   ST_READ   = 2'd1;
    localparam logic [1:0]   ST_DRAIN  = 2'd2;
    localparam logic [AW-1:0] LAST_ADDR = AW'(NUM_PRB - 1);
    localparam logic [2:0]   DRAIN_END = 3'(RD_LAT - 1);

    logic [1:0]    state_r, state_n;
    logic          sel_r, sel_n;
    logic [AW-1:0] addr_r;
    logic [2:0]    drain_cnt_r;
    logic [1:0]    pend_r, pend_n;
    logic          older_r, older_n;
    logic          ovf_r;

    logic [RD_LAT-1:0] vld_pipe_r;
    logic [RD_LAT-1:0] bank_pipe_r;
    logic [RD_LAT-1:0] last_pipe_r;
    logic [AW-1:0]     prb_pipe_r [RD_LAT];

    logic       issue_s, last_issue_s, drain_end_s, start_s, ovf_hit_s;
    logic [1:0] busy_bank_s, set_s, clr_s, rem_s;

    assign issue_s      = (state_r == ST_READ) && i_ds_ready;
    assign last_issue_s = issue_s && (addr_r == LAST_ADDR);
    assign drain_end_s  = (state_r == ST_DRAIN) && (drain_cnt_r == DRAIN_END);

    // Next-state and bank selection
    always_comb begin
        state_n = state_r;
        sel_n   = sel_r;
        start_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (pend_r != 2'b00) begin
                    state_n = ST_READ;
                    start_s = 1'b1;
                    if (pend_r == 2'b11) begin
                        sel_n = older_r;
                    end else begin
                        sel_n = pend_r[1];
                    end
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_READ: begin
                if (last_issue_s) begin
                    state_n = ST_DRAIN;
                end else begin
                    state_n = ST_READ;
                end
            end
            ST_DRAIN: begin
                if (drain_end_s) begin
                    if (pend_r[~sel_r]) begin
                        state_n = ST_READ;
                        sel_n   = ~sel_r;
                        start_s = 1'b1;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end else begin
                    state_n = ST_DRAIN;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // Pending flags, age tracking and overflow detection; the bank under read never re-arms
    always_comb begin
        busy_bank_s = (state_r != ST_IDLE) ? (sel_r ? 2'b10 : 2'b01) : 2'b00;
        set_s       = i_wr_done & ~pend_r & ~busy_bank_s;
        ovf_hit_s   = |(i_wr_done & (pend_r | busy_bank_s));
        clr_s       = start_s ? (sel_n ? 2'b10 : 2'b01) : 2'b00;
        rem_s       = pend_r & ~clr_s;
        pend_n      = rem_s | set_s;
        if (rem_s == 2'b01) begin
            older_n = 1'b0;
        end else if (rem_s == 2'b10) begin
            older_n = 1'b1;
        end else if (rem_s == 2'b00) begin
            older_n = (set_s == 2'b10);
        end else begin
            older_n = older_r;
        end
    end

    // Control state, address counter and drain timer
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r     <= ST_IDLE;
            sel_r       <= 1'b0;
            pend_r      <= 2'b00;
            older_r     <= 1'b0;
            ovf_r       <= 1'b0;
            addr_r      <= {AW{1'b0}};
            drain_cnt_r <= 3'd0;
        end else begin
            state_r <= state_n;
            sel_r   <= sel_n;
            pend_r  <= pend_n;
            older_r <= older_n;
            ovf_r   <= ovf_r | ovf_hit_s;
            if (last_issue_s) begin
                addr_r <= {AW{1'b0}};
            end else if (issue_s) begin
                addr_r <= addr_r + {{(AW-1){1'b0}}, 1'b1};
            end else begin
                addr_r <= addr_r;
            end
            if ((state_r == ST_DRAIN) && !drain_end_s) begin
                drain_cnt_r <= drain_cnt_r + 3'd1;
            end else begin
                drain_cnt_r <= 3'd0;
            end
        end
    end

    // Tag pipeline matching the RAM read latency
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vld_pipe_r  <= {RD_LAT{1'b0}};
            bank_pipe_r <= {RD_LAT{1'b0}};
            last_pipe_r <= {RD_LAT{1'b0}};
            for (int i = 0; i < RD_LAT; i++) begin
                prb_pipe_r[i] <= {AW{1'b0}};
            end
        end else begin
            for (int i = RD_LAT - 1; i > 0; i--) begin
                vld_pipe_r[i]  <= vld_pipe_r[i-1];
                bank_pipe_r[i] <= bank_pipe_r[i-1];
                last_pipe_r[i] <= last_pipe_r[i-1];
                prb_pipe_r[i]  <= prb_pipe_r[i-1];
            end
            vld_pipe_r[0]  <= issue_s;
            bank_pipe_r[0] <= issue_s & sel_r;
            last_pipe_r[0] <= last_issue_s;
            prb_pipe_r[0]  <= issue_s ? addr_r : {AW{1'b0}};
        end
    end

    // Per-antenna read enables and addresses for the selected bank only
    always_comb begin
        o_ren   = {ANT{1'b0}};
        o_raddr = {(ANT*AW){1'b0}};
        for (int a = 0; a < ANT; a++) begin
            if (((a >= HALF) ? 1'b1 : 1'b0) == sel_r) begin
                o_ren[a]             = issue_s;
                o_raddr[a*AW +: AW]  = (state_r == ST_READ) ? addr_r : {AW{1'b0}};
            end else begin
                o_ren[a]             = 1'b0;
                o_raddr[a*AW +: AW]  = {AW{1'b0}};
            end
        end
    end

    assign o_rd_vld   = vld_pipe_r[RD_LAT-1];
    assign o_rd_bank  = bank_pipe_r[RD_LAT-1];
    assign o_rd_prb   = prb_pipe_r[RD_LAT-1];
    assign o_sym_done = last_pipe_r[RD_LAT-1];
    assign o_busy     = (state_r != ST_IDLE);
    assign o_ovf      = ovf_r;

endmodule

// File: tb/tb_iq_ram_rd_sched.sv
// Directed bench for iq_ram_rd_sched: default instance plus a RD_LAT=4, NUM_PRB=8 instance.
module tb_iq_ram_rd_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  wr_done, wr_done4;
    logic        ds_ready, ds_ready4;
    logic [7:0]  ren, ren4;
    logic [63:0] raddr, raddr4;
    logic        rd_vld, rd_bank, sym_done, busy, ovf;
    logic        rd_vld4, rd_bank4, sym_done4, busy4, ovf4;
    logic [7:0]  rd_prb, rd_prb4;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    iq_ram_rd_sched #(.ANT(8), .NUM_PRB(132), .AW(8), .RD_LAT(2)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_wr_done(wr_done), .i_ds_ready(ds_ready),
        .o_ren(ren), .o_raddr(raddr), .o_rd_vld(rd_vld), .o_rd_bank(rd_bank),
        .o_rd_prb(rd_prb), .o_sym_done(sym_done), .o_busy(busy), .o_ovf(ovf)
    );

    iq_ram_rd_sched #(.ANT(8), .NUM_PRB(8), .AW(8), .RD_LAT(4)) dut4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_wr_done(wr_done4), .i_ds_ready(ds_ready4),
        .o_ren(ren4), .o_raddr(raddr4), .o_rd_vld(rd_vld4), .o_rd_bank(rd_bank4),
        .o_rd_prb(rd_prb4), .o_sym_done(sym_done4), .o_busy(busy4), .o_ovf(ovf4)
    );

    // Observation vectors: {ren, addr ant0, addr ant4, addr ant7, vld, bank, prb, sym_done, busy, ovf}
    logic [44:0] obs, obs4;
    assign obs  = {ren, raddr[7:0], raddr[39:32], raddr[63:56], rd_vld, rd_bank, rd_prb,
                   sym_done, busy, ovf};
    assign obs4 = {ren4, raddr4[7:0], raddr4[39:32], raddr4[63:56], rd_vld4, rd_bank4, rd_prb4,
                   sym_done4, busy4, ovf4};

    function automatic logic stall_iss(input int k);
        return ((k >= 2) && (k <= 51)) || ((k >= 62) && (k <= 143));
    endfunction

    function automatic int stall_addr(input int k);
        if (k <= 51) return k - 2;
        else if (k <= 61) return 50;
        else return k - 12;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; wr_done = 2'b11; ds_ready = 1'b1; wr_done4 = 2'b11; ds_ready4 = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (obs !== 45'h0) begin
            failures++; $display("FAIL reset_outputs got=%h exp=%h", obs, 45'h0);
        end
        checks++;
        if (obs4 !== 45'h0) begin
            failures++; $display("FAIL reset_outputs_lat4 got=%h exp=%h", obs4, 45'h0);
        end
        @(negedge clk);
        rst_n = 1'b1; wr_done = 2'b00; wr_done4 = 2'b00; ds_ready4 = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (obs !== 45'h0) begin
            failures++; $display("FAIL reset_release_idle got=%h exp=%h", obs, 45'h0);
        end
    endtask

    task automatic test_single_bank();
        logic er, ev, es, eb;
        logic [44:0] exp;
        for (int c = 0; c < 140; c++) begin
            @(negedge clk);
            wr_done = (c == 0) ? 2'b01 : 2'b00; ds_ready = 1'b1;
            #1;
            er = (c >= 2) && (c <= 133);
            ev = (c >= 4) && (c <= 135);
            es = (c == 135);
            eb = (c >= 2) && (c <= 135);
            exp = {er ? 8'h0F : 8'h00, er ? 8'(c - 2) : 8'h00, 8'h00, 8'h00,
                   ev, 1'b0, ev ? 8'(c - 4) : 8'h00, es, eb, 1'b0};
            checks++;
            if (obs !== exp) begin
                failures++; $display("FAIL single_bank c=%0d got=%h exp=%h", c, obs, exp);
            end
        end
    endtask

    task automatic test_stall();
        logic er, ev, es, eb;
        logic [44:0] exp;
        int nvld;
        nvld = 0;
        for (int c = 0; c < 152; c++) begin
            @(negedge clk);
            wr_done = (c == 0) ? 2'b01 : 2'b00;
            ds_ready = !((c >= 52) && (c <= 61));
            #1;
            er = stall_iss(c);
            ev = stall_iss(c - 2);
            es = (c == 145);
            eb = (c >= 2) && (c <= 145);
            exp = {er ? 8'h0F : 8'h00, ((c >= 2) && (c <= 143)) ? 8'(stall_addr(c)) : 8'h00,
                   8'h00, 8'h00, ev, 1'b0, ev ? 8'(stall_addr(c - 2)) : 8'h00, es, eb, 1'b0};
            if (rd_vld === 1'b1) nvld++;
            checks++;
            if (obs !== exp) begin
                failures++; $display("FAIL stall c=%0d got=%h exp=%h", c, obs, exp);
            end
        end
        checks++;
        if (nvld !== 132) begin
            failures++; $display("FAIL stall_vld_count got=%0d exp=%0d", nvld, 132);
        end
    endtask

    task automatic test_back_to_back();
        logic e0, e1, v0, v1, es, eb;
        logic [44:0] exp;
        for (int c = 0; c < 276; c++) begin
            @(negedge clk);
            wr_done = (c == 0) ? 2'b11 : 2'b00; ds_ready = 1'b1;
            #1;
            e0 = (c >= 2) && (c <= 133);
            e1 = (c >= 136) && (c <= 267);
            v0 = (c >= 4) && (c <= 135);
            v1 = (c >= 138) && (c <= 269);
            es = (c == 135) || (c == 269);
            eb = (c >= 2) && (c <= 269);
            exp = {e0 ? 8'h0F : (e1 ? 8'hF0 : 8'h00), e0 ? 8'(c - 2) : 8'h00,
                   e1 ? 8'(c - 136) : 8'h00, e1 ? 8'(c - 136) : 8'h00,
                   v0 | v1, v1, v0 ? 8'(c - 4) : (v1 ? 8'(c - 138) : 8'h00), es, eb, 1'b0};
            checks++;
            if (obs !== exp) begin
                failures++; $display("FAIL back_to_back c=%0d got=%h exp=%h", c, obs, exp);
            end
        end
    endtask

    task automatic test_overflow();
        logic er, ev, es, eb, eo;
        logic [44:0] exp;
        for (int c = 0; c < 146; c++) begin
            @(negedge clk);
            wr_done = ((c == 0) || (c == 72)) ? 2'b01 : 2'b00; ds_ready = 1'b1;
            #1;
            er = (c >= 2) && (c <= 133);
            ev = (c >= 4) && (c <= 135);
            es = (c == 135);
            eb = (c >= 2) && (c <= 135);
            eo = (c >= 73);
            exp = {er ? 8'h0F : 8'h00, er ? 8'(c - 2) : 8'h00, 8'h00, 8'h00,
                   ev, 1'b0, ev ? 8'(c - 4) : 8'h00, es, eb, eo};
            checks++;
            if (obs !== exp) begin
                failures++; $display("FAIL overflow c=%0d got=%h exp=%h", c, obs, exp);
            end
        end
    endtask

    task automatic test_reset_mid_read();
        logic er, ev, es, eb;
        logic [44:0] exp;
        for (int c = 0; c <= 42; c++) begin
            @(negedge clk);
            wr_done = (c == 0) ? 2'b01 : 2'b00; ds_ready = 1'b1;
            #1;
        end
        checks++;
        if (raddr[7:0] !== 8'd40) begin
            failures++; $display("FAIL mid_read_addr got=%0d exp=%0d", raddr[7:0], 8'd40);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== 45'h0) begin
            failures++; $display("FAIL async_reset got=%h exp=%h", obs, 45'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            #1;
            checks++;
            if (obs !== 45'h0) begin
                failures++; $display("FAIL post_reset_idle c=%0d got=%h exp=%h", c, obs, 45'h0);
            end
        end
        for (int c = 0; c < 140; c++) begin
            @(negedge clk);
            wr_done = (c == 0) ? 2'b10 : 2'b00; ds_ready = 1'b1;
            #1;
            er = (c >= 2) && (c <= 133);
            ev = (c >= 4) && (c <= 135);
            es = (c == 135);
            eb = (c >= 2) && (c <= 135);
            exp = {er ? 8'hF0 : 8'h00, 8'h00, er ? 8'(c - 2) : 8'h00, er ? 8'(c - 2) : 8'h00,
                   ev, ev, ev ? 8'(c - 4) : 8'h00, es, eb, 1'b0};
            checks++;
            if (obs !== exp) begin
                failures++; $display("FAIL bank1_after_reset c=%0d got=%h exp=%h", c, obs, exp);
            end
        end
    endtask

    task automatic test_rd_lat4();
        logic er, ev, es, eb;
        logic [44:0] exp;
        for (int c = 0; c < 19; c++) begin
            @(negedge clk);
            wr_done4 = (c == 0) ? 2'b01 : 2'b00; ds_ready4 = 1'b1;
            #1;
            er = (c >= 2) && (c <= 9);
            ev = (c >= 6) && (c <= 13);
            es = (c == 13);
            eb = (c >= 2) && (c <= 13);
            exp = {er ? 8'h0F : 8'h00, er ? 8'(c - 2) : 8'h00, 8'h00, 8'h00,
                   ev, 1'b0, ev ? 8'(c - 6) : 8'h00, es, eb, 1'b0};
            checks++;
            if (obs4 !== exp) begin
                failures++; $display("FAIL rd_lat4 c=%0d got=%h exp=%h", c, obs4, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_bank();
        test_stall();
        test_back_to_back();
        test_overflow();
        test_reset_mid_read();
        test_rd_lat4();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
